// File: rtl/uio_arb_pkg.sv
// Shared types and constants for the uio pad bus arbiter.
package uio_arb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        TURN,
        XFER
    } state_t;

    localparam logic DIR_READ  = 1'b0;
    localparam logic DIR_WRITE = 1'b1;

    localparam logic [7:0] OE_DRIVE = 8'hFF;
    localparam logic [7:0] OE_FLOAT = 8'h00;

endpackage

// File: rtl/uio_bus_arbiter_rr_picker.sv
// Combinational round-robin search: first set request at or after ptr, wrapping.
module rr_picker #(
    parameter int N = 4,
    parameter int W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] ptr,
    output logic [W-1:0] idx,
    output logic         found
);

    // Scan N positions starting at ptr; the earliest hit wins.
    always_comb begin
        int pos;
        idx   = '0;
        found = 1'b0;
        pos   = 0;
        for (int k = 0; k < N; k++) begin
            pos = int'(ptr) + k;
            if (pos >= N) begin
                pos = pos - N;
            end
            if (!found && req[pos]) begin
                found = 1'b1;
                idx   = W'(pos);
            end
        end
    end

endmodule

// File: rtl/uio_bus_arbiter.sv
// Round-robin arbiter sharing the bidirectional uio pad bus, with turnaround on direction change.
module uio_bus_arbiter
    import uio_arb_pkg::*;
#(
    parameter int NREQ       = 4,
    parameter int MAX_BURST  = 8,
    parameter int TURNAROUND = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ena,
    input  logic [NREQ-1:0]   req,
    input  logic [NREQ-1:0]   wr,
    input  logic [NREQ-1:0]   last,
    input  logic [NREQ*8-1:0] wdata,
    output logic [NREQ-1:0]   gnt,
    output logic [7:0]        rdata,
    output logic              rvalid,
    output logic              busy,
    input  logic [7:0]        uio_in,
    output logic [7:0]        uio_out,
    output logic [7:0]        uio_oe
);

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [NREQ-1:0] GNT_ONE = NREQ'(1);

    state_t          state;
    logic [IW-1:0]   idx;
    logic [IW-1:0]   rr_ptr;
    logic [IW-1:0]   pick_idx;
    logic [IW-1:0]   next_ptr;
    logic            pick_found;
    logic            bus_dir;
    logic            tgt_dir;
    logic [7:0]      beat_cnt;
    logic [1:0]      turn_cnt;
    logic            beat;
    logic            end_beat;
    logic            driving;

    rr_picker #(
        .N(NREQ),
        .W(IW)
    ) u_picker (
        .req  (req),
        .ptr  (rr_ptr),
        .idx  (pick_idx),
        .found(pick_found)
    );

    // Beat qualification, pointer advance and pad drive derived from the registered state.
    always_comb begin
        beat     = req[idx];
        end_beat = beat && (last[idx] || (beat_cnt == 8'(MAX_BURST - 1)));
        next_ptr = (idx == IW'(NREQ - 1)) ? '0 : idx + IW'(1);
        driving  = (state == XFER) && (bus_dir == DIR_WRITE);
        busy     = (state != IDLE);
        uio_oe   = driving ? OE_DRIVE : OE_FLOAT;
        uio_out  = driving ? wdata[8*idx +: 8] : 8'h00;
    end

    // Arbitration FSM: pick a requester, pay turnaround if the direction flips, then run the burst.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            idx      <= '0;
            rr_ptr   <= '0;
            gnt      <= '0;
            rdata    <= 8'h00;
            rvalid   <= 1'b0;
            bus_dir  <= DIR_READ;
            tgt_dir  <= DIR_READ;
            beat_cnt <= 8'd0;
            turn_cnt <= 2'd0;
        end else if (!ena) begin
            state    <= IDLE;
            gnt      <= '0;
            rvalid   <= 1'b0;
            beat_cnt <= 8'd0;
            turn_cnt <= 2'd0;
            bus_dir  <= DIR_READ;
        end else begin
            case (state)
                IDLE: begin
                    rvalid <= 1'b0;
                    if (pick_found) begin
                        idx     <= pick_idx;
                        tgt_dir <= wr[pick_idx];
                        if (wr[pick_idx] != bus_dir) begin
                            state    <= TURN;
                            turn_cnt <= 2'(TURNAROUND - 1);
                        end else begin
                            state    <= XFER;
                            gnt      <= GNT_ONE << pick_idx;
                            beat_cnt <= 8'd0;
                        end
                    end
                end
                TURN: begin
                    rvalid <= 1'b0;
                    if (turn_cnt == 2'd0) begin
                        bus_dir  <= tgt_dir;
                        state    <= XFER;
                        gnt      <= GNT_ONE << idx;
                        beat_cnt <= 8'd0;
                    end else begin
                        turn_cnt <= turn_cnt - 2'd1;
                    end
                end
                XFER: begin
                    rvalid <= beat && (bus_dir == DIR_READ);
                    if (beat && (bus_dir == DIR_READ)) begin
                        rdata <= uio_in;
                    end
                    if (!beat || end_beat) begin
                        state    <= IDLE;
                        gnt      <= '0;
                        rr_ptr   <= next_ptr;
                        beat_cnt <= 8'd0;
                    end else begin
                        beat_cnt <= beat_cnt + 8'd1;
                    end
                end
                default: begin
                    state <= IDLE;
                    gnt   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uio_bus_arbiter.sv
// Self-checking bench for uio_bus_arbiter: directed table, corner sequences, random vs reference model.
module tb_uio_bus_arbiter;

    localparam int NREQ       = 4;
    localparam int MAX_BURST  = 8;
    localparam int TURNAROUND = 1;

    logic        clk;
    logic        rst;
    logic        ena;
    logic [3:0]  req;
    logic [3:0]  wr;
    logic [3:0]  last;
    logic [31:0] wdata;
    logic [3:0]  gnt;
    logic [7:0]  rdata;
    logic        rvalid;
    logic        busy;
    logic [7:0]  uio_in;
    logic [7:0]  uio_out;
    logic [7:0]  uio_oe;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        rst;
        logic        ena;
        logic [3:0]  req;
        logic [3:0]  wr;
        logic [3:0]  last;
        logic [31:0] wdata;
        logic [7:0]  uio_in;
        logic [3:0]  gnt;
        logic        busy;
        logic [7:0]  oe;
        logic [7:0]  out;
        logic        rvalid;
        logic [7:0]  rdata;
    } vec_t;

    vec_t tbl[10];

    // Reference model state, expressed as transactions rather than the RTL encoding.
    int         m_mode;
    int         m_owner;
    int         m_wait;
    int         m_beats;
    int         m_ptr;
    bit         m_dir;
    bit         m_tgt;
    bit         m_rvalid;
    logic [7:0] m_rdata;

    uio_bus_arbiter #(
        .NREQ(NREQ),
        .MAX_BURST(MAX_BURST),
        .TURNAROUND(TURNAROUND)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .ena    (ena),
        .req    (req),
        .wr     (wr),
        .last   (last),
        .wdata  (wdata),
        .gnt    (gnt),
        .rdata  (rdata),
        .rvalid (rvalid),
        .busy   (busy),
        .uio_in (uio_in),
        .uio_out(uio_out),
        .uio_oe (uio_oe)
    );

    // Free-running clock, 10 time units per period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [29:0] packOut(logic [3:0] g, logic b, logic [7:0] oe,
                                            logic [7:0] o, logic rv, logic [7:0] rd);
        return {g, b, oe, o, rv, rd};
    endfunction

    function automatic vec_t mk(logic r, logic e, logic [3:0] q, logic [3:0] w, logic [3:0] l,
                                logic [31:0] wd, logic [7:0] ui, logic [3:0] g, logic b,
                                logic [7:0] oe, logic [7:0] o, logic rv, logic [7:0] rd);
        vec_t v;
        v.rst = r; v.ena = e; v.req = q; v.wr = w; v.last = l; v.wdata = wd; v.uio_in = ui;
        v.gnt = g; v.busy = b; v.oe = oe; v.out = o; v.rvalid = rv; v.rdata = rd;
        return v;
    endfunction

    task automatic applyStimulus(input logic r, input logic e, input logic [3:0] q,
                                 input logic [3:0] w, input logic [3:0] l,
                                 input logic [31:0] wd, input logic [7:0] ui);
        @(negedge clk);
        rst = r; ena = e; req = q; wr = w; last = l; wdata = wd; uio_in = ui;
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic modelReset();
        m_mode = 0; m_owner = 0; m_wait = 0; m_beats = 0; m_ptr = 0;
        m_dir = 1'b0; m_tgt = 1'b0; m_rvalid = 1'b0; m_rdata = 8'h00;
    endtask

    function automatic logic [29:0] modelPack();
        logic [3:0] g;
        logic [7:0] oe;
        logic [7:0] o;
        g  = (m_mode == 2) ? (4'b0001 << m_owner) : 4'b0000;
        oe = (m_mode == 2 && m_dir) ? 8'hFF : 8'h00;
        o  = (m_mode == 2 && m_dir) ? wdata[8*m_owner +: 8] : 8'h00;
        return packOut(g, m_mode != 0, oe, o, m_rvalid, m_rdata);
    endfunction

    // Advance the reference model by one clock using the inputs held across the edge.
    task automatic modelStep();
        if (rst) begin
            modelReset();
        end else if (!ena) begin
            m_mode = 0; m_rvalid = 1'b0; m_dir = 1'b0; m_beats = 0;
        end else if (m_mode == 0) begin
            m_rvalid = 1'b0;
            for (int k = 0; k < NREQ; k++) begin
                int j;
                j = (m_ptr + k) % NREQ;
                if (m_mode == 0 && req[j]) begin
                    m_owner = j;
                    m_tgt   = wr[j];
                    m_beats = 0;
                    if (m_tgt != m_dir) begin
                        m_mode = 1;
                        m_wait = TURNAROUND;
                    end else begin
                        m_mode = 2;
                    end
                end
            end
        end else if (m_mode == 1) begin
            m_rvalid = 1'b0;
            m_wait--;
            if (m_wait == 0) begin
                m_dir  = m_tgt;
                m_mode = 2;
            end
        end else begin
            if (req[m_owner]) begin
                m_beats++;
                m_rvalid = !m_dir;
                if (!m_dir) m_rdata = uio_in;
                if (last[m_owner] || m_beats == MAX_BURST) begin
                    m_mode = 0;
                    m_ptr  = (m_owner + 1) % NREQ;
                    m_beats = 0;
                end
            end else begin
                m_rvalid = 1'b0;
                m_mode   = 0;
                m_ptr    = (m_owner + 1) % NREQ;
                m_beats  = 0;
            end
        end
    endtask

    // Main test sequence.
    initial begin
        logic [3:0] exp_rr [10] = '{4'h0, 4'h1, 4'h0, 4'h2, 4'h0, 4'h4, 4'h0, 4'h8, 4'h0, 4'h1};
        logic [3:0] exp_bc [12] = '{4'h0, 4'h2, 4'h2, 4'h2, 4'h2, 4'h2, 4'h2, 4'h2, 4'h2,
                                    4'h0, 4'h0, 4'h8};
        logic [3:0] exp_ab [7]  = '{4'h0, 4'h0, 4'h1, 4'h1, 4'h0, 4'h0, 4'h1};
        logic [3:0] q;

        rst = 1'b1; ena = 1'b0; req = '0; wr = '0; last = '0; wdata = '0; uio_in = '0;

        // Reset then idle.
        applyStimulus(1, 0, 4'h0, 4'h0, 4'h0, 32'h0, 8'h00);
        applyStimulus(1, 0, 4'h0, 4'h0, 4'h0, 32'h0, 8'h00);
        applyStimulus(0, 1, 4'h0, 4'h0, 4'h0, 32'h0, 8'h00);
        checkOutput("reset_all", packOut(gnt, busy, uio_oe, uio_out, rvalid, rdata), 30'h0);
        for (int i = 0; i < 10; i++) begin
            applyStimulus(0, 1, 4'h0, 4'h0, 4'h0, 32'h0, 8'h00);
            checkOutput("idle_busy_oe", {busy, uio_oe}, 9'h000);
        end

        // Single read burst of three beats, then a write that needs one turnaround cycle.
        tbl[0] = mk(0, 1, 4'h1, 4'h0, 4'h0, 32'h0,        8'h00, 4'h0, 0, 8'h00, 8'h00, 0, 8'h00);
        tbl[1] = mk(0, 1, 4'h1, 4'h0, 4'h0, 32'h0,        8'hA5, 4'h1, 1, 8'h00, 8'h00, 0, 8'h00);
        tbl[2] = mk(0, 1, 4'h1, 4'h0, 4'h0, 32'h0,        8'h5A, 4'h1, 1, 8'h00, 8'h00, 1, 8'hA5);
        tbl[3] = mk(0, 1, 4'h1, 4'h0, 4'h1, 32'h0,        8'h3C, 4'h1, 1, 8'h00, 8'h00, 1, 8'h5A);
        tbl[4] = mk(0, 1, 4'h0, 4'h0, 4'h0, 32'h0,        8'h00, 4'h0, 0, 8'h00, 8'h00, 1, 8'h3C);
        tbl[5] = mk(0, 1, 4'h0, 4'h0, 4'h0, 32'h0,        8'h00, 4'h0, 0, 8'h00, 8'h00, 0, 8'h3C);
        tbl[6] = mk(0, 1, 4'h4, 4'h4, 4'h4, 32'h00C30000, 8'h00, 4'h0, 0, 8'h00, 8'h00, 0, 8'h3C);
        tbl[7] = mk(0, 1, 4'h4, 4'h4, 4'h4, 32'h00C30000, 8'h00, 4'h0, 1, 8'h00, 8'h00, 0, 8'h3C);
        tbl[8] = mk(0, 1, 4'h4, 4'h4, 4'h4, 32'h00C30000, 8'h00, 4'h4, 1, 8'hFF, 8'hC3, 0, 8'h3C);
        tbl[9] = mk(0, 1, 4'h0, 4'h0, 4'h0, 32'h0,        8'h00, 4'h0, 0, 8'h00, 8'h00, 0, 8'h3C);
        for (int i = 0; i < 10; i++) begin
            applyStimulus(tbl[i].rst, tbl[i].ena, tbl[i].req, tbl[i].wr, tbl[i].last,
                          tbl[i].wdata, tbl[i].uio_in);
            checkOutput($sformatf("table_row%0d", i),
                        packOut(gnt, busy, uio_oe, uio_out, rvalid, rdata),
                        packOut(tbl[i].gnt, tbl[i].busy, tbl[i].oe, tbl[i].out,
                                tbl[i].rvalid, tbl[i].rdata));
        end

        // Round robin over four readers with single-beat bursts.
        applyStimulus(1, 1, 4'h0, 4'h0, 4'h0, 32'h0, 8'h00);
        for (int i = 0; i < 10; i++) begin
            applyStimulus(0, 1, 4'hF, 4'h0, 4'hF, 32'h0, 8'h11);
            checkOutput($sformatf("rr_gnt%0d", i), gnt, exp_rr[i]);
        end

        // Burst cap on requester 1, then hand-over to writer 3 through a turnaround.
        applyStimulus(1, 1, 4'h0, 4'h0, 4'h0, 32'h0, 8'h00);
        for (int i = 0; i < 12; i++) begin
            applyStimulus(0, 1, 4'hA, 4'h8, 4'h8, 32'h96000000, 8'h22);
            checkOutput($sformatf("cap_gnt%0d", i), gnt, exp_bc[i]);
            if (i == 10) checkOutput("cap_turn_busy_oe", {busy, uio_oe}, 9'h100);
            if (i == 11) checkOutput("cap_write_oe_out", {uio_oe, uio_out}, 16'hFF96);
        end

        // Abort a write burst with ena low on its second beat, then re-enable.
        applyStimulus(1, 1, 4'h0, 4'h0, 4'h0, 32'h0, 8'h00);
        for (int i = 0; i < 7; i++) begin
            applyStimulus(0, (i != 3), 4'h1, 4'h1, 4'h0, 32'h00000077, 8'h00);
            checkOutput($sformatf("abort_gnt%0d", i), gnt, exp_ab[i]);
            if (i == 3) checkOutput("abort_beat2_oe", uio_oe, 8'hFF);
            if (i == 4) checkOutput("abort_idle_busy_oe", {busy, uio_oe}, 9'h000);
            if (i == 5) checkOutput("abort_turn_busy_oe", {busy, uio_oe}, 9'h100);
            if (i == 6) checkOutput("abort_regrant_out", {uio_oe, uio_out}, 16'hFF77);
        end

        // Randomized traffic against the reference model.
        q = 4'h0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 2) == 0) q = 4'($urandom);
            if (i == 0) begin
                applyStimulus(1, 1, q, 4'($urandom), 4'($urandom & $urandom), $urandom, 8'($urandom));
            end else begin
                applyStimulus(($urandom_range(0, 299) == 0), ($urandom_range(0, 19) != 0), q,
                              4'($urandom), 4'($urandom & $urandom), $urandom, 8'($urandom));
                checkOutput("random", packOut(gnt, busy, uio_oe, uio_out, rvalid, rdata), modelPack());
            end
            @(posedge clk);
            modelStep();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
